sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM (sram_sp, 1-cycle read latency) between a write requester (buffet fill / write scanner side) and a read requester (read scanner side).
- Grants at most one access per cycle, round-robin on conflict.
- Owns a 2-entry read-response buffer so the read side can back-pressure without losing SRAM data.
- Sits between the fiber access logic and the memory macro.

Parameters:
ADDR_W, 9, SRAM address width
DATA_W, 64, SRAM word width
RSP_DEPTH, 2, read-response buffer entries (fixed at 2; credit logic sized for it)

Ports:
clk  in  1  clock
flush  in  1  synchronous active-high reset; clears all state on the rising clk edge
clk_en  in  1  global clock enable; 0 holds every register and forces wen_to_mem=ren_to_mem=0, both readies=0
wr_req_valid  in  1  write request valid
wr_req_ready  out  1  write granted this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  read granted this cycle
rd_addr  in  ADDR_W  read address
rd_rsp_data  out  DATA_W  read response data
rd_rsp_valid  out  1  read response valid
rd_rsp_ready  in  1  read response accepted
addr_to_mem  out  ADDR_W  SRAM address
data_to_mem  out  DATA_W  SRAM write data
wen_to_mem  out  1  SRAM write enable
ren_to_mem  out  1  SRAM read enable
data_from_mem  in  DATA_W  SRAM read data, valid the cycle after ren_to_mem

Behaviour:
- Reset (flush=1): last_grant=GNT_RD, so the first conflict goes to write; inflight=0; response buffer empty.
  - Reset output values: rd_rsp_valid=0, wen_to_mem=0, ren_to_mem=0, wr_req_ready=0, rd_req_ready=0, addr_to_mem=0, data_to_mem=0.
- Grant logic is combinational in the same cycle.
  - rd_eligible = rd_req_valid & (occupancy + inflight < RSP_DEPTH).
  - Only one of wr_req_valid, rd_eligible set: grant it.
  - Both set: grant the one not equal to last_grant.
  - last_grant updates only on a real grant.
- Grant outputs:
  - Write grant: wen_to_mem=1, addr_to_mem=wr_addr, data_to_mem=wr_data, wr_req_ready=1.
  - Read grant: ren_to_mem=1, addr_to_mem=rd_addr, rd_req_ready=1.
  - No grant: addr_to_mem and data_to_mem hold 0.
- Readies never depend on the requester's own valid being asserted for fewer than one cycle. The requester must hold valid, address and data stable until ready.
- inflight: 1-bit register, set on a read grant. The next cycle data_from_mem is pushed into the response buffer and inflight clears (or stays set if read is granted again).
- Response buffer:
  - FIFO, 2 entries; rd_rsp_data comes from the head register (no combinational path from data_from_mem).
  - Push and pop in the same cycle are allowed.
  - The credit rule guarantees no overflow; overflow is an assertion failure.
- Read latency: grant at cycle N, push at N+1, rd_rsp_valid at N+2 at the earliest.
- Write-then-read to the same address in consecutive grants returns the new data (single port, serialized).
- flush mid-operation: inflight data is discarded and buffered responses are dropped. Requesters are flushed by the same signal.
- clk_en=0: no grants, no push/pop, all state held.
  - An inflight read whose data arrives while clk_en=0 is not lost; the SRAM is also gated by clk_en.

Optional Feature:
- SRAM_ARB_PERF_EN, defined: adds 32-bit outputs wr_grant_cnt, rd_grant_cnt, conflict_cnt and rd_stall_cnt.
  - rd_stall_cnt counts cycles with rd_req_valid=1 and no read grant.
  - All four saturate at 0xFFFFFFFF and clear on flush.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package sram_arb_pkg:
  - grant_e enum {GNT_NONE, GNT_WR, GNT_RD}
  - localparam RSP_DEPTH_MAX=2
  - perf counter width constant 32
- Sub-module sram_arb_rsp_fifo: 2-entry registered FIFO with push/pop, count output and an overflow assertion.

Test Plan:
- Write only, wr_addr 0..7 with data 0x100+i, back-to-back → wr_req_ready=1 every cycle, 8 consecutive wen_to_mem pulses, no ren.
- Both valid for 6 cycles (wr to addr 3, rd from addr 3) → grants alternate WR,RD,WR,RD,WR,RD; first read returns the written data.
- Read addrs 0..3 with rd_rsp_ready=0 → exactly 2 read grants, then rd_req_ready=0. Raising rd_rsp_ready returns data in address order with no loss.
- Read grant at cycle N, rd_rsp_ready=1 → rd_rsp_valid first high at N+2 with the SRAM contents of rd_addr.
- flush asserted one cycle after a read grant → rd_rsp_valid stays 0 and buffer count is 0. The next read still works.
- clk_en=0 for 5 cycles with both valid → no grants. With SRAM_ARB_PERF_EN defined, conflict_cnt unchanged and rd_stall_cnt unchanged.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Optional performance counters are enabled with SRAM_ARB_PERF_EN.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

  localparam int RSP_DEPTH_MAX = 2;
  localparam int PERF_CNT_W    = 32;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                    input logic                  inc);
    return (inc && (v != '1)) ? v + PERF_CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/sram_arb_rsp_fifo.sv
// Two-entry registered read-response FIFO; head_data comes straight from a flop.
// Credit logic upstream guarantees it never overflows.
module sram_arb_rsp_fifo
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  localparam logic [1:0] FULL = 2'(RSP_DEPTH_MAX);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic [1:0]        count_after_pop;

  always_comb begin
    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    count_after_pop = count_q - {1'b0, pop};
    head_d          = pop ? tail_q : head_q;
    tail_d          = tail_q;
    count_d         = count_after_pop;
    if (push) begin
      if (count_after_pop == 2'd0) head_d = push_data;
      else                         tail_d = push_data;
      count_d = count_after_pop + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    if (flush) count_q <= '0;
    else       count_q <= count_d;
  end

  // NOTE: the data slots are deliberately not reset; count_q alone says which of them hold valid data.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign head_data = head_q;
  assign count     = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (flush)
    !(push && !pop && (count_q == FULL)));
  a_no_underflow: assert property (@(posedge clk) disable iff (flush)
    !(pop && (count_q == 2'd0)));

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a write and a read requester.
// Define SRAM_ARB_PERF_EN to add saturating grant/conflict/stall counters.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 64,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              clk_en,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [ADDR_W-1:0] addr_to_mem,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              wen_to_mem,
  output logic              ren_to_mem,
  input  logic [DATA_W-1:0] data_from_mem
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] wr_grant_cnt,
  output logic [PERF_CNT_W-1:0] rd_grant_cnt,
  output logic [PERF_CNT_W-1:0] conflict_cnt,
  output logic [PERF_CNT_W-1:0] rd_stall_cnt
`endif
);

  localparam logic [2:0] RSP_DEPTH_L = 3'(RSP_DEPTH);

  grant_e     last_grant_q, last_grant_d;
  grant_e     grant;
  logic       inflight_q, inflight_d;
  logic [1:0] rsp_count;
  logic [2:0] credits_used;
  logic       rd_eligible;
  logic       active;
  logic       rsp_push;
  logic       rsp_pop;

  assign active       = clk_en & ~flush;
  // A read may only issue if its data is guaranteed a slot in the response FIFO.
  assign credits_used = {1'b0, rsp_count} + {2'b00, inflight_q};
  assign rd_eligible  = rd_req_valid & (credits_used < RSP_DEPTH_L);

  always_comb begin
    grant = GNT_NONE;
    if (active) begin
      if (wr_req_valid && rd_eligible) grant = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;
      else if (wr_req_valid)           grant = GNT_WR;
      else if (rd_eligible)            grant = GNT_RD;
    end
  end

  always_comb begin
    wr_req_ready = 1'b0;
    rd_req_ready = 1'b0;
    wen_to_mem   = 1'b0;
    ren_to_mem   = 1'b0;
    addr_to_mem  = '0;
    data_to_mem  = '0;
    case (grant)
      GNT_WR: begin
        wr_req_ready = 1'b1;
        wen_to_mem   = 1'b1;
        addr_to_mem  = wr_addr;
        data_to_mem  = wr_data;
      end
      GNT_RD: begin
        rd_req_ready = 1'b1;
        ren_to_mem   = 1'b1;
        addr_to_mem  = rd_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_grant_d = (grant != GNT_NONE) ? grant : last_grant_q;
    // The SRAM is gated by clk_en too, so a pending read keeps its data until the next enabled edge.
    inflight_d   = clk_en ? (grant == GNT_RD) : inflight_q;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      last_grant_q <= GNT_RD;
      inflight_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
    end
  end

  assign rsp_push     = inflight_q & clk_en;
  assign rd_rsp_valid = (rsp_count != 2'd0) & clk_en;
  assign rsp_pop      = rd_rsp_valid & rd_rsp_ready;

  sram_arb_rsp_fifo #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .flush     (flush),
    .push      (rsp_push),
    .push_data (data_from_mem),
    .pop       (rsp_pop),
    .head_data (rd_rsp_data),
    .count     (rsp_count)
  );

`ifdef SRAM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [PERF_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [PERF_CNT_W-1:0] conf_cnt_q, conf_cnt_d;
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    wr_cnt_d    = sat_inc(wr_cnt_q, grant == GNT_WR);
    rd_cnt_d    = sat_inc(rd_cnt_q, grant == GNT_RD);
    conf_cnt_d  = sat_inc(conf_cnt_q, active & wr_req_valid & rd_eligible);
    stall_cnt_d = sat_inc(stall_cnt_q, active & rd_req_valid & (grant != GNT_RD));
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      conf_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      conf_cnt_q  <= conf_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wr_grant_cnt = wr_cnt_q;
  assign rd_grant_cnt = rd_cnt_q;
  assign conflict_cnt = conf_cnt_q;
  assign rd_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of arbitration, credits and response latency.
module tb_sram_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              flush, clk_en;
  logic              wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] wr_addr, rd_addr, addr_to_mem;
  logic [DATA_W-1:0] wr_data, rd_rsp_data, data_to_mem, data_from_mem;
  logic              rd_rsp_valid, rd_rsp_ready, wen_to_mem, ren_to_mem;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] wr_grant_cnt, rd_grant_cnt, conflict_cnt, rd_stall_cnt;
`endif

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(2)) dut (
    .clk           (clk),
    .flush         (flush),
    .clk_en        (clk_en),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_addr       (rd_addr),
    .rd_rsp_data   (rd_rsp_data),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_ready  (rd_rsp_ready),
    .addr_to_mem   (addr_to_mem),
    .data_to_mem   (data_to_mem),
    .wen_to_mem    (wen_to_mem),
    .ren_to_mem    (ren_to_mem),
    .data_from_mem (data_from_mem)
`ifdef SRAM_ARB_PERF_EN
    ,
    .wr_grant_cnt  (wr_grant_cnt),
    .rd_grant_cnt  (rd_grant_cnt),
    .conflict_cnt  (conflict_cnt),
    .rd_stall_cnt  (rd_stall_cnt)
`endif
  );

  // Contents of a never-written SRAM word.
  function automatic logic [63:0] init_word(input int a);
    return {32'hDEAD_0000 + 32'(a), 32'h5A5A_0000 + 32'(a)};
  endfunction

  // SRAM macro model: one-cycle read latency, gated by clk_en.
  logic [63:0] sram     [512];
  bit          sram_vld [512];
  always @(posedge clk) begin
    if (clk_en) begin
      if (wen_to_mem) begin
        sram[addr_to_mem]     <= data_to_mem;
        sram_vld[addr_to_mem] <= 1'b1;
      end
      if (ren_to_mem)
        data_from_mem <= sram_vld[addr_to_mem] ? sram[addr_to_mem] : init_word(int'(addr_to_mem));
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] data;
    int          age;   // enabled clock edges since the read was granted
  } rsp_t;

  rsp_t        sb_q[$];
  logic [63:0] ref_mem [int];
  bit          last_was_wr = 1'b0;
  bit          started     = 1'b0;
  int          popped      = 0;

  function automatic logic [63:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

`ifdef SRAM_ARB_PERF_EN
  int unsigned m_wr = 0, m_rd = 0, m_conf = 0, m_stall = 0;
`endif

  // Response monitor: the head of the scoreboard is deliverable two enabled edges after its grant.
  bit exp_rsp_v;
  always @(negedge clk) begin
    if (started) begin
      exp_rsp_v = clk_en && (sb_q.size() > 0) && (sb_q[0].age >= 2);
      check("rd_rsp_valid", 64'(rd_rsp_valid), 64'(exp_rsp_v));
      popped = 0;
      if (rd_rsp_valid && rd_rsp_ready && exp_rsp_v) begin
        check("rd_rsp_data", rd_rsp_data, sb_q[0].data);
        void'(sb_q.pop_front());
        popped = 1;
      end
    end
  end

  // Grant checker: predicts this cycle's grant from the requests and the outstanding-read count.
  bit exp_wr, exp_rd, rd_el, en;
  int outstanding;
  always @(negedge clk) begin
    if (started) begin
      #1;
      outstanding = sb_q.size() + popped;
      en     = clk_en && !flush;
      rd_el  = rd_req_valid && (outstanding < 2);
      exp_wr = en && wr_req_valid && (!rd_el || !last_was_wr);
      exp_rd = en && rd_el && (!wr_req_valid || last_was_wr);
      check("wr_req_ready", 64'(wr_req_ready), 64'(exp_wr));
      check("rd_req_ready", 64'(rd_req_ready), 64'(exp_rd));
      check("wen_to_mem", 64'(wen_to_mem), 64'(exp_wr));
      check("ren_to_mem", 64'(ren_to_mem), 64'(exp_rd));
      check("addr_to_mem", 64'(addr_to_mem),
            exp_wr ? 64'(wr_addr) : (exp_rd ? 64'(rd_addr) : 64'd0));
      if (!exp_rd) check("data_to_mem", data_to_mem, exp_wr ? wr_data : 64'd0);
`ifdef SRAM_ARB_PERF_EN
      check("wr_grant_cnt", 64'(wr_grant_cnt), 64'(m_wr));
      check("rd_grant_cnt", 64'(rd_grant_cnt), 64'(m_rd));
      check("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
      check("rd_stall_cnt", 64'(rd_stall_cnt), 64'(m_stall));
      if (flush) begin
        m_wr = 0; m_rd = 0; m_conf = 0; m_stall = 0;
      end else if (en) begin
        if (exp_wr)                  m_wr++;
        if (exp_rd)                  m_rd++;
        if (wr_req_valid && rd_el)   m_conf++;
        if (rd_req_valid && !exp_rd) m_stall++;
      end
`endif
      if (flush) begin
        sb_q.delete();
        last_was_wr = 1'b0;
      end else if (clk_en) begin
        if (exp_wr) begin
          ref_mem[int'(wr_addr)] = wr_data;
          last_was_wr = 1'b1;
        end
        if (exp_rd) begin
          sb_q.push_back('{data: ref_read(int'(rd_addr)), age: 0});
          last_was_wr = 1'b0;
        end
        foreach (sb_q[i]) sb_q[i].age++;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit wr_acc = 1'b0, rd_acc = 1'b0;

  task automatic tick();
    @(negedge clk);
    wr_acc = wr_req_ready;
    rd_acc = rd_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush        = 1'b1;
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(input int n);
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    rd_rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_acc;
    int  j;
    bit  was_flush;
    flush        = 1'b1;
    clk_en       = 1'b1;
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    wr_addr      = '0;
    rd_addr      = '0;
    wr_data      = '0;
    rd_rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;
    tick();
    flush = 1'b0;

    // Back-to-back writes, one per cycle.
    n_acc = 0;
    wr_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_addr = 9'(i);
      wr_data = 64'h100 + 64'(i);
      tick();
      if (wr_acc) n_acc++;
    end
    wr_req_valid = 1'b0;
    check("write_burst_grants", 64'(n_acc), 64'd8);
    tick();

    // Conflict on the same address: alternation starts with write, read sees the new data.
    do_flush();
    rd_rsp_ready = 1'b1;
    wr_req_valid = 1'b1; wr_addr = 9'd3; wr_data = 64'hA000;
    rd_req_valid = 1'b1; rd_addr = 9'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (wr_acc) wr_data = wr_data + 64'd1;
    end
    drain(4);

    // Back-pressured reads: only two credits, then stall until the consumer drains.
    do_flush();
    rd_rsp_ready = 1'b0;
    j = 0;
    rd_req_valid = 1'b1; rd_addr = 9'd0;
    repeat (6) begin
      tick();
      if (rd_acc) begin j++; rd_addr = 9'(j); end
    end
    check("credit_limited_grants", 64'(j), 64'd2);
    rd_rsp_ready = 1'b1;
    for (int c = 0; c < 30 && j < 4; c++) begin
      tick();
      if (rd_acc) begin
        j++;
        if (j == 4) rd_req_valid = 1'b0;
        else        rd_addr = 9'(j);
      end
    end
    check("all_reads_granted", 64'(j), 64'd4);
    drain(4);

    // Flush one cycle after a read grant discards the response; a later read still works.
    rd_req_valid = 1'b1; rd_addr = 9'd5;
    tick();
    rd_req_valid = 1'b0;
    do_flush();
    drain(3);
    rd_req_valid = 1'b1; rd_addr = 9'd6;
    tick();
    drain(4);

    // clk_en low with both requesters pending, and a read left in flight across a gated window.
    wr_req_valid = 1'b1; wr_addr = 9'd7; wr_data = 64'hBEEF;
    rd_req_valid = 1'b1; rd_addr = 9'd1;
    clk_en = 1'b0;
    repeat (5) tick();
    clk_en = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    rd_addr = 9'd7;
    tick();
    rd_req_valid = 1'b0;
    clk_en = 1'b0;
    repeat (3) tick();
    clk_en = 1'b1;
    drain(5);

    // Randomized traffic with back-pressure, clock gating and occasional flushes.
    was_flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      clk_en       = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 49) == 0);
      rd_rsp_ready = ($urandom_range(0, 9) < 7);
      if (!wr_req_valid || wr_acc || was_flush) begin
        wr_req_valid = ($urandom_range(0, 9) < 6);
        wr_addr      = 9'($urandom_range(0, 15));
        wr_data      = {$urandom, $urandom};
      end
      if (!rd_req_valid || rd_acc || was_flush) begin
        rd_req_valid = ($urandom_range(0, 9) < 6);
        rd_addr      = 9'($urandom_range(0, 15));
      end
      was_flush = flush;
      tick();
    end
    flush  = 1'b0;
    clk_en = 1'b1;
    drain(8);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
